// File: rtl/s2c_pkt_responder.sv
// s2c protocol responder: receives one request packet word-serially, executes the
// addressed function, then returns a same-layout response before accepting more.
module s2c_pkt_responder #(
  parameter int DATA_SIZE = 16,
  parameter int NUM_ID    = 8,
  parameter int W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic              busy,
  output logic [NUM_ID-1:0] active_ids,
  output logic [15:0]       pkt_cnt
);

  localparam int PKT_WORDS = DATA_SIZE + 3;
  localparam int IW        = $clog2(PKT_WORDS);
  localparam int IDW       = (NUM_ID > 1) ? $clog2(NUM_ID) : 1;
  localparam logic [IW-1:0] LAST = IW'(PKT_WORDS - 1);

  localparam logic [1:0] RX    = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] TX    = 2'd3;

  logic [1:0]    state, state_nx;
  logic [IW-1:0] idx;
  logic [W-1:0]  id_q, fn_q, ret_q;
  logic [W-1:0]  data_q [DATA_SIZE];
  logic          len_err;

  logic [W-1:0]  sum, ret_nx;
  logic          zero_data, set_id, clr_id;
  logic          accept, tx_hs;
  logic [IDW-1:0] id_sel;

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == TX);
  assign tx_hs     = out_valid && out_ready;
  assign out_last  = (state == TX) && (idx == LAST);
  assign busy      = !((state == RX) && (idx == '0));
  assign id_sel    = id_q[IDW-1:0];

  always_comb begin
    state_nx = state;
    case (state)
      RX: if (accept) begin
        if (idx == LAST) state_nx = in_last ? EXEC : DRAIN;
        else if (in_last) state_nx = EXEC;
      end
      DRAIN:   if (accept && in_last) state_nx = EXEC;
      EXEC:    state_nx = TX;
      default: if (tx_hs && (idx == LAST)) state_nx = RX;
    endcase
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < DATA_SIZE; i++) sum = sum + data_q[i];
  end

  // Check order matters: length error dominates, then id range, then setup state.
  always_comb begin
    ret_nx    = '0;
    zero_data = 1'b0;
    set_id    = 1'b0;
    clr_id    = 1'b0;
    if (len_err) begin
      ret_nx = W'(4);
    end else if (id_q >= W'(NUM_ID)) begin
      ret_nx    = W'(3);
      zero_data = 1'b1;
    end else if (fn_q == W'(0)) begin
      set_id = 1'b1;
    end else if (fn_q == W'(3)) begin
      clr_id = 1'b1;
    end else if (((fn_q == W'(1)) || (fn_q == W'(2))) && !active_ids[id_sel]) begin
      ret_nx    = W'(1);
      zero_data = 1'b1;
    end else if (fn_q == W'(1)) begin
      ret_nx = '0;
    end else if (fn_q == W'(2)) begin
      ret_nx    = sum;
      zero_data = 1'b1;
    end else begin
      ret_nx    = W'(2);
      zero_data = 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    if (state == TX) begin
      if (idx == IW'(0))      out_data = id_q;
      else if (idx == IW'(1)) out_data = fn_q;
      else if (idx == IW'(2)) out_data = ret_q;
      else
        for (int unsigned i = 0; i < DATA_SIZE; i++)
          if (idx == IW'(i + 3)) out_data = data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RX;
      idx        <= '0;
      in_ready   <= 1'b0;
      id_q       <= '0;
      fn_q       <= '0;
      ret_q      <= '0;
      len_err    <= 1'b0;
      active_ids <= '0;
      pkt_cnt    <= '0;
      for (int unsigned i = 0; i < DATA_SIZE; i++) data_q[i] <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == RX) || (state_nx == DRAIN);
      case (state)
        RX: if (accept) begin
          // Word 0 clears the buffer so a short packet returns zeros for missing data.
          if (idx == IW'(0)) id_q <= in_data;
          if (idx == IW'(1)) fn_q <= in_data;
          else if (idx == IW'(0)) fn_q <= '0;
          for (int unsigned i = 0; i < DATA_SIZE; i++) begin
            if (idx == IW'(0)) data_q[i] <= '0;
            else if (idx == IW'(i + 3)) data_q[i] <= in_data;
          end
          len_err <= (idx == LAST) ? !in_last : in_last;
          idx     <= (state_nx == RX) ? idx + 1'b1 : '0;
        end
        DRAIN: idx <= '0;
        EXEC: begin
          ret_q <= ret_nx;
          if (zero_data)
            for (int unsigned i = 0; i < DATA_SIZE; i++) data_q[i] <= '0;
          if (set_id) active_ids[id_sel] <= 1'b1;
          if (clr_id) active_ids[id_sel] <= 1'b0;
          idx <= '0;
        end
        default: if (tx_hs) begin
          if (idx == LAST) begin
            idx     <= '0;
            pkt_cnt <= pkt_cnt + 16'd1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s2c_pkt_responder.sv
// Directed bench for s2c_pkt_responder with hand-computed response packets.
module tb_s2c_pkt_responder;

  localparam int PW = 19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic [7:0]  active_ids;
  logic [15:0] pkt_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;
  logic [31:0] req   [32];
  logic [31:0] exp_w [PW];

  s2c_pkt_responder #(.DATA_SIZE(16), .NUM_ID(8), .W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .active_ids(active_ids), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hdr(input logic [31:0] id, input logic [31:0] fn, input logic [31:0] ret);
    req[0] = id; req[1] = fn; req[2] = 32'h0;
    exp_w[0] = id; exp_w[1] = fn; exp_w[2] = ret;
  endtask

  task automatic send(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = req[k];
      in_last  = (k == n - 1);
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("accept_timeout", t, 0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic recv(input bit bp);
    int k, t;
    bit v, r;
    k = 0; t = 0;
    chk("lat_exec_valid", 32'(out_valid), 0);
    chk("exec_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("lat_tx_valid", 32'(out_valid), 1);
    while (k < PW && t < 400) begin
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      v = out_valid;
      chk("tx_valid", 32'(out_valid), 1);
      chk($sformatf("word%0d", k), out_data, exp_w[k]);
      chk("out_last", 32'(out_last), 32'(k == PW - 1));
      chk("tx_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      if (v && r) k++;
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    if (k < PW) chk("rx_timeout", k, PW);
    chk("post_in_ready", 32'(in_ready), 1);
    chk("post_busy", 32'(busy), 0);
    chk("post_valid", 32'(out_valid), 0);
    exp_cnt++;
    chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_active", 32'(active_ids), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(in_ready), 1);

    // ECHO id 2 without setup -> ret 1, data zeroed
    hdr(2, 1, 1);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'(i); exp_w[3+i] = 0; end
    send(PW); recv(0);

    // SETUP id 2, then ECHO
    hdr(2, 0, 0);
    for (int i = 0; i < 16; i++) begin req[3+i] = 0; exp_w[3+i] = 0; end
    send(PW); recv(0);
    chk("active_setup2", 32'(active_ids), 32'h04);
    hdr(2, 1, 0);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'hA500_0000 + 32'(i); exp_w[3+i] = req[3+i]; end
    send(PW); recv(0);

    // SETUP 5, SUM of all-ones, RELEASE 5, SUM again
    hdr(5, 0, 0);
    for (int i = 0; i < 16; i++) begin req[3+i] = 0; exp_w[3+i] = 0; end
    send(PW); recv(0);
    chk("active_setup5", 32'(active_ids), 32'h24);
    hdr(5, 2, 32'hFFFF_FFF0);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'hFFFF_FFFF; exp_w[3+i] = 0; end
    send(PW); recv(0);
    hdr(5, 3, 0);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'(i + 9); exp_w[3+i] = req[3+i]; end
    send(PW); recv(0);
    chk("active_release5", 32'(active_ids), 32'h04);
    hdr(5, 2, 1);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'hFFFF_FFFF; exp_w[3+i] = 0; end
    send(PW); recv(0);

    // short packet: in_last on word 5
    hdr(2, 1, 4);
    for (int i = 0; i < 16; i++) begin req[3+i] = (i < 3) ? 32'd7 : 32'd0; exp_w[3+i] = req[3+i]; end
    send(6); recv(0);

    // long packet: 22 words, 3 drained
    hdr(2, 1, 4);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'(i + 1); exp_w[3+i] = req[3+i]; end
    req[19] = 32'hDEAD_0001; req[20] = 32'hDEAD_0002; req[21] = 32'hDEAD_0003;
    send(22); recv(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_extra_valid", 32'(out_valid), 0);
    end
    chk("no_extra_cnt", 32'(pkt_cnt), 32'(exp_cnt));

    // id out of range
    hdr(8, 1, 3);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'(i + 3); exp_w[3+i] = 0; end
    send(PW); recv(0);

    // SETUP id 0, unknown fn 9
    hdr(0, 0, 0);
    for (int i = 0; i < 16; i++) begin req[3+i] = 0; exp_w[3+i] = 0; end
    send(PW); recv(0);
    chk("active_setup0", 32'(active_ids), 32'h05);
    hdr(0, 9, 2);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'h100 + 32'(i); exp_w[3+i] = 0; end
    send(PW); recv(0);

    // backpressure on ECHO id 2
    hdr(2, 1, 0);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'h5A5A_0000 + 32'(i); exp_w[3+i] = req[3+i]; end
    send(PW); recv(1);

    // reset during TX
    hdr(2, 1, 0);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'(i); exp_w[3+i] = req[3+i]; end
    send(PW);
    @(negedge clk);
    chk("mid_tx_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_last", 32'(out_last), 0);
    chk("midrst_active", 32'(active_ids), 0);
    chk("midrst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    chk("midrst_rdy_after", 32'(in_ready), 1);

    // setup state lost: ECHO id 2 now rejected
    hdr(2, 1, 1);
    for (int i = 0; i < 16; i++) begin req[3+i] = 32'(i + 1); exp_w[3+i] = 0; end
    send(PW); recv(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s2c_pkt_responder.md
Name: s2c_pkt_responder

Overview:
- Synthesizable responder end of the s2c packet protocol: receives a request packet word-serially, executes the addressed function and returns a response packet in the same layout.
- Packet layout, word order identical both directions: id, fn, ret, data[0..DATA_SIZE-1]; PKT_WORDS = DATA_SIZE+3.
- Handles one packet at a time (in_ready held low until the response is fully sent), giving the same single-outstanding-request serialization the initiator side enforces.

Parameters:
- DATA_SIZE, 16, payload words per packet
- NUM_ID, 8, number of valid requester ids (0..NUM_ID-1)
- W, 32, word width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request word valid
- in_ready  out  1  request word accepted when in_valid&&in_ready
- in_data  in  W  request word
- in_last  in  1  marks final request word
- out_valid  out  1  response word valid
- out_ready  in  1  response word consumed when out_valid&&out_ready
- out_data  out  W  response word
- out_last  out  1  high on final response word (index PKT_WORDS-1)
- busy  out  1  high in any state other than RX with word index 0
- active_ids  out  NUM_ID  bit n set = id n is set up
- pkt_cnt  out  16  completed responses, wraps 0xFFFF->0

Behaviour:
- Reset (clk edge with rst_n=0): state RX, word index 0, in_ready=0 during reset and 1 on the first cycle after, out_valid=0, out_data=0, out_last=0, busy=0, active_ids=0, pkt_cnt=0, data buffer cleared. Reset mid-packet aborts with no response. Setup state is lost.
- States: RX, DRAIN, EXEC, TX.
- RX:
  - in_ready=1. Each accepted word is stored by index: 0->id, 1->fn, 2->ignored, 3..PKT_WORDS-1->data[idx-3].
  - Accept with in_last at idx<PKT_WORDS-1: unreceived data words become 0, len_err=1, go to EXEC.
  - Accept at idx=PKT_WORDS-1 with in_last: go to EXEC.
  - Accept at idx=PKT_WORDS-1 without in_last: len_err=1, go to DRAIN.
- DRAIN: in_ready=1. Accepted words are discarded. On the in_last word, go to EXEC.
- EXEC: exactly one cycle, in_ready=0. Computes ret and response data, then goes to TX. Check order (first match wins):
  - len_err -> ret=4, data returned unchanged.
  - id>=NUM_ID -> ret=3.
  - fn=0 SETUP -> set active_ids[id], ret=0.
  - fn=3 RELEASE -> clear active_ids[id], ret=0. No error if the id is not set.
  - fn=1 ECHO or fn=2 SUM with active_ids[id]=0 -> ret=1.
  - fn=1 ECHO -> ret=0, data unchanged.
  - fn=2 SUM -> ret = modulo-2^W sum of data[0..DATA_SIZE-1], data zeroed.
  - any other fn -> ret=2.
  - Response data is zeroed for ret 1/2/3. SETUP and RELEASE return data unchanged.
- TX:
  - out_valid=1, out_data = word at tx idx: 0->id, 1->fn, 2->ret, 3..->data.
  - out_data and out_last are held stable while out_ready=0.
  - Index advances on handshake. At idx=PKT_WORDS-1 (out_last=1) the handshake increments pkt_cnt and returns to RX idx 0; in_ready rises the following cycle.
- Latency: first response word valid 2 cycles after the last request word is accepted.
- Throughput: 1 word/cycle each direction.
- in_ready=0 in EXEC and TX.
- Request words presented while in_ready=0 are not consumed.

Test Plan:
- Reset, then fn=1 ECHO id=2 without prior SETUP, data[i]=i -> response 2,1,1, then 16 zeros; out_last only on word 18; pkt_cnt=1.
- SETUP id=2, then ECHO id=2 data[i]=0xA5000000+i -> ret=0, data echoed; active_ids=0x04.
- SETUP id=5, then SUM id=5 with data[i]=0xFFFFFFFF for all i -> ret=0xFFFFFFF0, data all 0. Then RELEASE 5 and SUM 5 -> ret=1.
- Length errors:
  - in_last on word 5 (data[0..2]=7) -> ret=4, data=7,7,7,0...
  - 22-word packet -> words 19..21 drained, ret=4, no extra response.
- id=8 -> ret=3. fn=9 with id=0 set up -> ret=2.
- Backpressure: out_ready toggling randomly 50% -> stable out_data across stalls, in_ready=0 until final handshake.
- Reset asserted mid-TX -> out_valid=0 next cycle, active_ids=0, pkt_cnt=0.
